ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 81 ++++++++
 tb/tb_ex_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: registered ALU execute stage with valid/ready handshake; ALU_SLT_EN adds signed set-less-than (0111).
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        illegal,
  output logic [15:0] op_count
);
`ifdef ALU_SLT_EN
  localparam bit SLT_EN = 1'b1;
`else
  localparam bit SLT_EN = 1'b0;
`endif
  logic        out_valid_q, out_valid_d, zero_q, zero_d, rw_q, rw_d, illegal_q, illegal_d;
  logic [31:0] result_q, result_d, alu_res;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept, xfer, is_add, is_sub, is_and, is_or, is_slt, legal;
  always_comb begin
    is_add   = alu_ctrl == 4'b0010;
    is_sub   = alu_ctrl == 4'b0110;
    is_and   = alu_ctrl == 4'b0000;
    is_or    = alu_ctrl == 4'b0001;
    is_slt   = SLT_EN && alu_ctrl == 4'b0111;
    legal    = is_add || is_sub || is_and || is_or || is_slt;
    alu_res  = is_add ? op_a + op_b :
               is_sub ? op_a - op_b :
               is_and ? op_a & op_b :
               is_or  ? op_a | op_b :
               is_slt ? {31'd0, $signed(op_a) < $signed(op_b)} : 32'd0;
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready && !flush;
    xfer     = out_valid_q && out_ready;
    out_valid_d = accept ? 1'b1 : (xfer || flush) ? 1'b0 : out_valid_q;
    result_d    = accept ? alu_res : result_q;
    zero_d      = accept ? alu_res == 32'd0 : zero_q;
    rd_d        = accept ? rd : rd_q;
    rw_d        = accept ? reg_write && legal : rw_q;
    illegal_d   = accept ? !legal : illegal_q;
    cnt_d       = cnt_q + {15'd0, xfer};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      zero_q      <= 1'b0;
      rd_q        <= 5'd0;
      rw_q        <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign out_rd        = rd_q;
  assign out_reg_write = rw_q;
  assign illegal       = illegal_q;
  assign op_count      = cnt_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage, one task per scenario.
module tb_ex_stage;
  logic        clk = 1'b0, rst, flush, in_valid, in_ready, reg_write, out_valid, out_ready;
  logic        zero, out_reg_write, illegal;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd, out_rd;
  logic [15:0] op_count;
  int passed = 0, total = 0;

  ex_stage dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .rd(rd), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .illegal(illegal), .op_count(op_count));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic w);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; rd = r; reg_write = w;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd1, 1'b1); in_valid = 1'b0;
    step(); step();
    total++;
    if ({out_valid, result, zero, out_rd, out_reg_write, illegal, op_count} !== 57'd0) $display("FAIL reset_state: got valid=%b res=%h zero=%b rd=%0d rw=%b ill=%b cnt=%0d want all 0", out_valid, result, zero, out_rd, out_reg_write, illegal, op_count);
    else passed++;
    rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    step(); in_valid = 1'b0;
    total++;
    if ({out_valid, result, zero, out_rd, out_reg_write, illegal, op_count} !== {1'b1, 32'd0, 1'b1, 5'd5, 1'b1, 1'b0, 16'd0})
      $display("FAIL add_wrap: got valid=%b res=%h zero=%b rd=%0d rw=%b ill=%b cnt=%0d want 1 00000000 1 5 1 0 0", out_valid, result, zero, out_rd, out_reg_write, illegal, op_count);
    else passed++;
    step();
    total++;
    if ({out_valid, op_count} !== {1'b0, 16'd1}) $display("FAIL add_xfer: got valid=%b cnt=%0d want 0 1", out_valid, op_count); else passed++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(4'b0110, 32'd10, 32'd3, 5'd7, 1'b1);
    step();
    drive(4'b0010, 32'd1, 32'd1, 5'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, result, zero, out_rd, in_ready} !== {1'b1, 32'd7, 1'b0, 5'd7, 1'b0})
        $display("FAIL stall_hold[%0d]: got valid=%b res=%0d zero=%b rd=%0d in_ready=%b want 1 7 0 7 0", i, out_valid, result, zero, out_rd, in_ready);
      else passed++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready); else passed++;
    step();
    total++;
    if ({out_valid, op_count} !== {1'b0, 16'd2}) $display("FAIL stall_xfer: got valid=%b cnt=%0d want 0 2", out_valid, op_count); else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(4'b0000, 32'hF0F0, 32'h0FF0, 5'd1, 1'b1);
    step();
    total++;
    if ({out_valid, result} !== {1'b1, 32'h00F0}) $display("FAIL b2b_and: got valid=%b res=%h want 1 000000f0", out_valid, result); else passed++;
    drive(4'b0001, 32'hF000, 32'h000F, 5'd2, 1'b1);
    step();
    total++;
    if ({out_valid, result, out_rd, op_count} !== {1'b1, 32'hF00F, 5'd2, 16'd3}) $display("FAIL b2b_or: got valid=%b res=%h rd=%0d cnt=%0d want 1 0000f00f 2 3", out_valid, result, out_rd, op_count); else passed++;
    in_valid = 1'b0;
    step();
    total++;
    if ({out_valid, op_count} !== {1'b0, 16'd4}) $display("FAIL b2b_drain: got valid=%b cnt=%0d want 0 4", out_valid, op_count); else passed++;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(4'b1111, 32'd5, 32'd6, 5'd3, 1'b1);
    step();
    total++;
    if ({out_valid, illegal, out_reg_write, result, zero, out_rd} !== {1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 5'd3})
      $display("FAIL illegal_1111: got valid=%b ill=%b rw=%b res=%h zero=%b rd=%0d want 1 1 0 00000000 1 3", out_valid, illegal, out_reg_write, result, zero, out_rd);
    else passed++;
    drive(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    step();
    total++;
`ifdef ALU_SLT_EN
    if ({out_valid, illegal, out_reg_write, result, zero} !== {1'b1, 1'b0, 1'b1, 32'd1, 1'b0})
      $display("FAIL slt: got valid=%b ill=%b rw=%b res=%h zero=%b want 1 0 1 00000001 0", out_valid, illegal, out_reg_write, result, zero);
`else
    if ({out_valid, illegal, out_reg_write, result, zero} !== {1'b1, 1'b1, 1'b0, 32'd0, 1'b1})
      $display("FAIL slt_illegal: got valid=%b ill=%b rw=%b res=%h zero=%b want 1 1 0 00000000 1", out_valid, illegal, out_reg_write, result, zero);
`endif
    else passed++;
    in_valid = 1'b0;
    step();
    total++;
    if ({out_valid, op_count} !== {1'b0, 16'd6}) $display("FAIL illegal_count: got valid=%b cnt=%0d want 0 6", out_valid, op_count); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(4'b0010, 32'd2, 32'd3, 5'd1, 1'b1);
    step();
    total++;
    if ({out_valid, result} !== {1'b1, 32'd5}) $display("FAIL flush_pre: got valid=%b res=%0d want 1 5", out_valid, result); else passed++;
    flush = 1'b1;
    drive(4'b0010, 32'd8, 32'd8, 5'd2, 1'b1);
    step();
    total++;
    if ({out_valid, op_count} !== {1'b0, 16'd7}) $display("FAIL flush_xfer: got valid=%b cnt=%0d want 0 7", out_valid, op_count); else passed++;
    step();
    total++;
    if ({out_valid, op_count} !== {1'b0, 16'd7}) $display("FAIL flush_block: got valid=%b cnt=%0d want 0 7", out_valid, op_count); else passed++;
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    drive(4'b0010, 32'd4, 32'd4, 5'd9, 1'b1);
    step(); in_valid = 1'b0;
    step();
    total++;
    if ({out_valid, result} !== {1'b1, 32'd8}) $display("FAIL rst_stall_pre: got valid=%b res=%0d want 1 8", out_valid, result); else passed++;
    rst = 1'b1; out_ready = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; #1;
    total++;
    if ({out_valid, result, zero, out_rd, out_reg_write, illegal, op_count, in_ready} !== {57'd0, 1'b1})
      $display("FAIL rst_stall: got valid=%b res=%h zero=%b rd=%0d rw=%b ill=%b cnt=%0d in_ready=%b want all 0, in_ready 1", out_valid, result, zero, out_rd, out_reg_write, illegal, op_count, in_ready);
    else passed++;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    drive(4'b0010, 32'd0, 32'd0, 5'd0, 1'b0);
    for (int i = 0; i < 65536; i++) step();
    total++;
    if ({out_valid, op_count} !== {1'b1, 16'hFFFF}) $display("FAIL wrap_pre: got valid=%b cnt=%h want 1 ffff", out_valid, op_count); else passed++;
    in_valid = 1'b0;
    step();
    total++;
    if ({out_valid, op_count} !== {1'b0, 16'h0000}) $display("FAIL wrap: got valid=%b cnt=%h want 0 0000", out_valid, op_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_stall();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
